sequenciador_fila_comandos: RTL and testbench
=============================================

Name: sequenciador_fila_comandos

Overview:
- Command-queued controller that sequences the stack and ALU datapath of the calculator.
- Accepts one-cycle command pulses (push a value, or run an ALU op) from the button and edge-detect logic, and buffers them in a small FIFO so presses made while the ALU is busy are not lost.
- Drives the stack, input mux, ALU start/opcode and flag-latch controls, with a per-op timeout.
- Sits between the edge-detect pulses and the stack, ALU and flag registers.

Parameters:
- FILA_PROF, 4, FIFO depth in commands; must be a power of 2, at least 2.
- TIMEOUT_CICLOS, 255, maximum cycles spent in ESPERA_ULA before abort.
- LARG_DADO, 8, width of pushed data.

Ports:
- Clk  in  1  system clock (slow divided clock)
- Reset  in  1  synchronous, active-high reset
- cmd_valido  in  1  one-cycle command strobe
- cmd_tipo  in  1  0 = push cmd_dado, 1 = ALU op
- cmd_dado  in  LARG_DADO  value to push (SW[7:0])
- cmd_op  in  3  ALU opcode
- ula_pronto  in  1  ALU done pulse/level
- limpa_erros  in  1  clears sticky error flags
- pilha_empilha  out  1  stack push strobe
- pilha_sel_sw  out  1  stack input mux: 1 = pilha_dado, 0 = ALU result
- pilha_dado  out  LARG_DADO  data for SW-side of stack mux
- ula_inicia  out  1  ALU start strobe
- ula_op_code  out  3  opcode, held stable for the whole op
- empilha_resultado  out  1  flag-register load strobe
- ocupado  out  1  FSM not in OCIOSO
- fila_vazia  out  1  FIFO empty
- fila_cheia  out  1  FIFO holds FILA_PROF entries
- num_cmds  out  log2(FILA_PROF)+1  current FIFO occupancy
- erro_transbordo  out  1  sticky: a command was dropped
- erro_timeout  out  1  sticky: ALU op aborted

Behaviour:
- Reset, sampled on the rising edge of Clk:
  - FIFO emptied (num_cmds=0, fila_vazia=1, fila_cheia=0).
  - FSM goes to OCIOSO.
  - All strobes, pilha_dado, ula_op_code, ocupado and both error flags become 0.
  - Reset during any state aborts the operation; no further strobes are issued.
- FIFO:
  - Entry is {tipo, dado, op}, 12 bits.
  - Enqueue happens on an edge where cmd_valido=1 and (not full, or a pop occurs on the same edge).
  - Full with a simultaneous pop: the command is accepted and occupancy is unchanged.
  - Full without a pop: the command is dropped and erro_transbordo is set to 1.
  - Pop occurs only in OCIOSO when the FIFO is not empty; there is never a pop from an empty FIFO.
  - Pointers wrap modulo FILA_PROF.
- FSM states:
  - OCIOSO: if not fila_vazia, pop the head into the current-command register, go to EXEC.
  - EXEC, tipo=0: for exactly 1 cycle, pilha_empilha=1, pilha_sel_sw=1, pilha_dado=dado. Then go to OCIOSO.
  - EXEC, tipo=1: for exactly 1 cycle, ula_inicia=1, with ula_op_code=op. Clear the timeout counter. Go to ESPERA_ULA.
  - ESPERA_ULA: the counter increments each cycle.
    - If ula_pronto=1, go to GRAVA.
    - Else if counter = TIMEOUT_CICLOS-1, set erro_timeout=1 and go to OCIOSO with no push.
    - ula_pronto has priority over timeout on the same cycle.
    - ula_pronto is ignored in every state except ESPERA_ULA.
  - GRAVA: for exactly 1 cycle, pilha_empilha=1, pilha_sel_sw=0, empilha_resultado=1. Go to OCIOSO.
- Output holding rules:
  - ula_op_code is registered. It takes cmd op when entering EXEC for an op command, holds through GRAVA, and keeps its last value in OCIOSO (drives the opcode display).
  - pilha_dado holds its last pushed value.
- Latency:
  - Command accepted at edge E0 into an empty FIFO with an idle FSM: pop at E1, EXEC strobes high in the cycle following E1.
  - Push command: 1 strobe cycle.
  - Op command: start, then k wait cycles, then 1 GRAVA cycle.
  - Back-to-back queued commands have 1 OCIOSO cycle between them.
- Error flags: limpa_erros=1 clears both sticky flags. If a set condition occurs on the same edge, set wins.
- ocupado=1 in EXEC, ESPERA_ULA and GRAVA.

Test Plan:
- Reset, then push cmd_dado=0x2A → two edges later pilha_empilha=1 and pilha_sel_sw=1 for 1 cycle with pilha_dado=0x2A; fila_vazia returns to 1.
- Op cmd_op=3'b010, ula_pronto asserted 5 cycles after ula_inicia → ula_inicia pulse 1 cycle; ula_op_code=2 stable throughout; one GRAVA cycle with pilha_empilha=1, pilha_sel_sw=0, empilha_resultado=1.
- Issue 6 commands while the FSM waits on an op (ula_pronto held 0, FILA_PROF=4) → num_cmds saturates at 4, fila_cheia=1, erro_transbordo=1; after ula_pronto the 4 queued commands execute in order.
- Op with ula_pronto never asserted → erro_timeout=1 exactly TIMEOUT_CICLOS cycles after ula_inicia, no push, FSM back in OCIOSO; limpa_erros clears it.
- Full FIFO, cmd_valido on the same edge as a pop → command accepted, num_cmds stays 4, erro_transbordo stays 0.
- Reset asserted in ESPERA_ULA with 2 queued commands → next cycle all outputs 0, num_cmds=0, and no GRAVA strobe even if ula_pronto=1 afterwards.

Source files
------------

// File: rtl/sequenciador_fila_comandos.sv
// Command sequencer for the calculator datapath: queues push/ALU-op pulses in a small FIFO
// and drives the stack, ALU start/opcode and result-latch strobes, with a per-op timeout.
//
// state       | meaning
// OCIOSO      | idle; pops the FIFO head whenever the FIFO is not empty
// EXEC        | one cycle: stack push of the popped value, or ALU start
// ESPERA_ULA  | waiting for ula_pronto while the timeout counter runs
// GRAVA       | one cycle: push the ALU result and load the flag register
module sequenciador_fila_comandos #(
    parameter int FILA_PROF      = 4,
    parameter int TIMEOUT_CICLOS = 255,
    parameter int LARG_DADO      = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       cmd_valido,
    input  logic                       cmd_tipo,
    input  logic [LARG_DADO-1:0]       cmd_dado,
    input  logic [2:0]                 cmd_op,
    input  logic                       ula_pronto,
    input  logic                       limpa_erros,
    output logic                       pilha_empilha,
    output logic                       pilha_sel_sw,
    output logic [LARG_DADO-1:0]       pilha_dado,
    output logic                       ula_inicia,
    output logic [2:0]                 ula_op_code,
    output logic                       empilha_resultado,
    output logic                       ocupado,
    output logic                       fila_vazia,
    output logic                       fila_cheia,
    output logic [$clog2(FILA_PROF):0] num_cmds,
    output logic                       erro_transbordo,
    output logic                       erro_timeout
);

    localparam int PTR_W = $clog2(FILA_PROF);
    localparam int ENT_W = 1 + LARG_DADO + 3;
    localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    localparam logic [PTR_W:0]   OCUP_MAX  = (PTR_W + 1)'(FILA_PROF);
    localparam logic [PTR_W:0]   OCUP_UM   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_UM    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_UM    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(TIMEOUT_CICLOS - 1);

    localparam logic [1:0] OCIOSO     = 2'd0;
    localparam logic [1:0] EXEC       = 2'd1;
    localparam logic [1:0] ESPERA_ULA = 2'd2;
    localparam logic [1:0] GRAVA      = 2'd3;

    logic [ENT_W-1:0]     fila_mem [FILA_PROF];
    logic [PTR_W-1:0]     ptr_le;
    logic [PTR_W-1:0]     ptr_esc;
    logic [PTR_W:0]       ocupacao;
    logic [ENT_W-1:0]     cabeca;
    logic                 cab_tipo;
    logic [LARG_DADO-1:0] cab_dado;
    logic [2:0]           cab_op;
    logic                 desenfileira;
    logic                 enfileira;
    logic                 descarta;

    logic [1:0]           estado;
    logic                 tipo_atual;
    logic [CNT_W-1:0]     cont_timeout;
    logic                 estouro;

    // Entry layout is {tipo, dado, op}
    assign cabeca   = fila_mem[ptr_le];
    assign cab_tipo = cabeca[ENT_W-1];
    assign cab_dado = cabeca[3 +: LARG_DADO];
    assign cab_op   = cabeca[2:0];

    assign fila_vazia = (ocupacao == '0);
    assign fila_cheia = (ocupacao == OCUP_MAX);
    assign num_cmds   = ocupacao;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a command then
    assign desenfileira = (estado == OCIOSO) && !fila_vazia;
    assign enfileira    = cmd_valido && (!fila_cheia || desenfileira);
    assign descarta     = cmd_valido && fila_cheia && !desenfileira;

    assign estouro = (estado == ESPERA_ULA) && !ula_pronto && (cont_timeout == CNT_FINAL);

    always_ff @(posedge Clk) begin
        if (enfileira) begin
            fila_mem[ptr_esc] <= {cmd_tipo, cmd_dado, cmd_op};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_le   <= '0;
            ptr_esc  <= '0;
            ocupacao <= '0;
        end else begin
            if (enfileira) begin
                ptr_esc <= ptr_esc + PTR_UM;
            end
            if (desenfileira) begin
                ptr_le <= ptr_le + PTR_UM;
            end
            if (enfileira && !desenfileira) begin
                ocupacao <= ocupacao + OCUP_UM;
            end else if (!enfileira && desenfileira) begin
                ocupacao <= ocupacao - OCUP_UM;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado       <= OCIOSO;
            tipo_atual   <= 1'b0;
            pilha_dado   <= '0;
            ula_op_code  <= '0;
            cont_timeout <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (desenfileira) begin
                        tipo_atual <= cab_tipo;
                        if (cab_tipo) begin
                            ula_op_code <= cab_op;
                        end else begin
                            pilha_dado <= cab_dado;
                        end
                        estado <= EXEC;
                    end
                end
                EXEC: begin
                    if (tipo_atual) begin
                        cont_timeout <= '0;
                        estado       <= ESPERA_ULA;
                    end else begin
                        estado <= OCIOSO;
                    end
                end
                ESPERA_ULA: begin
                    if (ula_pronto) begin
                        estado <= GRAVA;
                    end else if (cont_timeout == CNT_FINAL) begin
                        estado <= OCIOSO;
                    end else begin
                        cont_timeout <= cont_timeout + CNT_UM;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    // Sticky flags: a set condition on the same edge as limpa_erros wins
    always_ff @(posedge Clk) begin
        if (Reset) begin
            erro_transbordo <= 1'b0;
            erro_timeout    <= 1'b0;
        end else begin
            erro_transbordo <= descarta | (erro_transbordo & ~limpa_erros);
            erro_timeout    <= estouro | (erro_timeout & ~limpa_erros);
        end
    end

    assign pilha_empilha     = ((estado == EXEC) && !tipo_atual) || (estado == GRAVA);
    assign pilha_sel_sw      = (estado == EXEC) && !tipo_atual;
    assign ula_inicia        = (estado == EXEC) && tipo_atual;
    assign empilha_resultado = (estado == GRAVA);
    assign ocupado           = (estado != OCIOSO);

endmodule

// File: tb/tb_sequenciador_fila_comandos.sv
// Bench for sequenciador_fila_comandos: directed scenarios plus random traffic, checked every
// cycle against a queue-based command model.
module tb_sequenciador_fila_comandos;

    localparam int FILA_PROF      = 4;
    localparam int TIMEOUT_CICLOS = 255;
    localparam int LARG_DADO      = 8;

    logic                       Clk = 1'b0;
    logic                       Reset;
    logic                       cmd_valido;
    logic                       cmd_tipo;
    logic [LARG_DADO-1:0]       cmd_dado;
    logic [2:0]                 cmd_op;
    logic                       ula_pronto;
    logic                       limpa_erros;
    logic                       pilha_empilha;
    logic                       pilha_sel_sw;
    logic [LARG_DADO-1:0]       pilha_dado;
    logic                       ula_inicia;
    logic [2:0]                 ula_op_code;
    logic                       empilha_resultado;
    logic                       ocupado;
    logic                       fila_vazia;
    logic                       fila_cheia;
    logic [$clog2(FILA_PROF):0] num_cmds;
    logic                       erro_transbordo;
    logic                       erro_timeout;

    always #5 Clk = ~Clk;

    sequenciador_fila_comandos #(
        .FILA_PROF      (FILA_PROF),
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .LARG_DADO      (LARG_DADO)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .cmd_valido        (cmd_valido),
        .cmd_tipo          (cmd_tipo),
        .cmd_dado          (cmd_dado),
        .cmd_op            (cmd_op),
        .ula_pronto        (ula_pronto),
        .limpa_erros       (limpa_erros),
        .pilha_empilha     (pilha_empilha),
        .pilha_sel_sw      (pilha_sel_sw),
        .pilha_dado        (pilha_dado),
        .ula_inicia        (ula_inicia),
        .ula_op_code       (ula_op_code),
        .empilha_resultado (empilha_resultado),
        .ocupado           (ocupado),
        .fila_vazia        (fila_vazia),
        .fila_cheia        (fila_cheia),
        .num_cmds          (num_cmds),
        .erro_transbordo   (erro_transbordo),
        .erro_timeout      (erro_timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Reference model: a queue of pending commands plus the command being executed,
    // tracked by its age in cycles since it was taken from the queue.
    typedef struct {
        logic                 tipo;
        logic [LARG_DADO-1:0] dado;
        logic [2:0]           op;
    } cmd_t;

    cmd_t                 fila_m[$];
    bit                   iniciado = 0;
    bit                   m_ativo;
    cmd_t                 m_cmd;
    int                   m_idade;
    bit                   m_grava;
    logic [LARG_DADO-1:0] m_pdado;
    logic [2:0]           m_op;
    bit                   m_eo;
    bit                   m_et;

    always @(posedge Clk) begin : modelo
        bit   pop;
        bit   cheia_antes;
        bit   set_ov;
        bit   set_to;
        cmd_t novo;
        if (Reset) begin
            iniciado = 1;
            fila_m.delete();
            m_ativo  = 0;
            m_idade  = 0;
            m_grava  = 0;
            m_pdado  = '0;
            m_op     = '0;
            m_eo     = 0;
            m_et     = 0;
        end else if (iniciado) begin
            pop         = !m_ativo && (fila_m.size() != 0);
            cheia_antes = (fila_m.size() == FILA_PROF);
            set_ov      = 0;
            set_to      = 0;
            if (m_ativo) begin
                if (!m_cmd.tipo) begin
                    m_ativo = 0;
                end else if (m_grava) begin
                    m_ativo = 0;
                    m_grava = 0;
                end else if (m_idade == 0) begin
                    m_idade = 1;
                end else if (ula_pronto) begin
                    m_grava = 1;
                end else if (m_idade == TIMEOUT_CICLOS) begin
                    m_ativo = 0;
                    set_to  = 1;
                end else begin
                    m_idade++;
                end
            end
            if (pop) begin
                m_cmd   = fila_m.pop_front();
                m_ativo = 1;
                m_idade = 0;
                m_grava = 0;
                if (m_cmd.tipo) m_op = m_cmd.op;
                else            m_pdado = m_cmd.dado;
            end
            if (cmd_valido) begin
                if (!cheia_antes || pop) begin
                    novo.tipo = cmd_tipo;
                    novo.dado = cmd_dado;
                    novo.op   = cmd_op;
                    fila_m.push_back(novo);
                end else begin
                    set_ov = 1;
                end
            end
            m_eo = set_ov || (m_eo && !limpa_erros);
            m_et = set_to || (m_et && !limpa_erros);
        end
    end

    always @(negedge Clk) begin : compara
        bit e_push;
        bit e_inicia;
        bit e_grava;
        if (iniciado) begin
            e_push   = m_ativo && !m_cmd.tipo;
            e_inicia = m_ativo && m_cmd.tipo && (m_idade == 0);
            e_grava  = m_ativo && m_grava;
            chk("pilha_empilha", pilha_empilha, e_push || e_grava);
            chk("pilha_sel_sw", pilha_sel_sw, e_push);
            chk("pilha_dado", pilha_dado, m_pdado);
            chk("ula_inicia", ula_inicia, e_inicia);
            chk("ula_op_code", ula_op_code, m_op);
            chk("empilha_resultado", empilha_resultado, e_grava);
            chk("ocupado", ocupado, m_ativo);
            chk("num_cmds", num_cmds, fila_m.size());
            chk("fila_vazia", fila_vazia, fila_m.size() == 0);
            chk("fila_cheia", fila_cheia, fila_m.size() == FILA_PROF);
            chk("erro_transbordo", erro_transbordo, m_eo);
            chk("erro_timeout", erro_timeout, m_et);
        end
    end

    task automatic step(input logic v, input logic t, input logic [LARG_DADO-1:0] d,
                        input logic [2:0] o, input logic pr, input logic lim, input logic rst);
        cmd_valido  = v;
        cmd_tipo    = t;
        cmd_dado    = d;
        cmd_op      = o;
        ula_pronto  = pr;
        limpa_erros = lim;
        Reset       = rst;
        @(negedge Clk);
    endtask

    task automatic idle(input logic pr = 1'b0);
        step(1'b0, 1'b0, '0, 3'd0, pr, 1'b0, 1'b0);
    endtask

    task automatic push_cmd(input logic [LARG_DADO-1:0] d);
        step(1'b1, 1'b0, d, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic op_cmd(input logic [2:0] o);
        step(1'b1, 1'b1, '0, o, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int vistos;

        // Reset
        step(1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_num_cmds", num_cmds, 0);
        chk("rst_fila_vazia", fila_vazia, 1);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_pilha_dado", pilha_dado, 0);

        // Single push: strobe two edges after the command
        push_cmd(8'h2A);
        chk("t1_num_cmds", num_cmds, 1);
        idle();
        chk("t1_empilha", pilha_empilha, 1);
        chk("t1_sel_sw", pilha_sel_sw, 1);
        chk("t1_dado", pilha_dado, 'h2A);
        chk("t1_vazia", fila_vazia, 1);
        idle();
        chk("t1_empilha_fim", pilha_empilha, 0);
        chk("t1_ocioso", ocupado, 0);

        // ALU op finished by ula_pronto
        op_cmd(3'b010);
        idle();
        chk("t2_inicia", ula_inicia, 1);
        chk("t2_op", ula_op_code, 2);
        repeat (4) idle();
        idle(1'b1);
        chk("t2_grava_empilha", pilha_empilha, 1);
        chk("t2_grava_sel", pilha_sel_sw, 0);
        chk("t2_grava_res", empilha_resultado, 1);
        chk("t2_grava_op", ula_op_code, 2);
        idle();
        chk("t2_ocioso", ocupado, 0);
        chk("t2_op_mantido", ula_op_code, 2);

        // Overflow while the ALU is busy, then in-order drain
        op_cmd(3'b101);
        idle();
        idle();
        for (int i = 0; i < 6; i++) push_cmd(8'(8'h11 + i));
        chk("t3_num_cmds", num_cmds, 4);
        chk("t3_cheia", fila_cheia, 1);
        chk("t3_transbordo", erro_transbordo, 1);
        idle(1'b1);
        vistos = 0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (pilha_sel_sw) begin
                chk("t3_ordem", pilha_dado, 'h11 + vistos);
                vistos++;
            end
        end
        chk("t3_qtd_push", vistos, 4);
        chk("t3_vazia", fila_vazia, 1);

        // Full FIFO accepting a command on the popping edge
        step(1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("t5_limpa", erro_transbordo, 0);
        op_cmd(3'b011);
        idle();
        idle();
        for (int i = 0; i < 4; i++) push_cmd(8'(8'h31 + i));
        chk("t5_cheia", fila_cheia, 1);
        idle(1'b1);
        idle();
        chk("t5_ocioso", ocupado, 0);
        push_cmd(8'h77);
        chk("t5_num_cmds", num_cmds, 4);
        chk("t5_transbordo", erro_transbordo, 0);
        chk("t5_ocupado", ocupado, 1);
        repeat (12) idle();

        // Timeout: count edges from the one sampling ula_inicia until erro_timeout rises
        op_cmd(3'b110);
        idle();
        chk("t4_inicia", ula_inicia, 1);
        idle();
        n = 0;
        while (erro_timeout !== 1'b1 && n < 400) begin
            idle();
            n++;
        end
        chk("t4_ciclos", n, TIMEOUT_CICLOS);
        chk("t4_ocioso", ocupado, 0);
        chk("t4_sem_push", pilha_empilha, 0);
        step(1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("t4_limpa", erro_timeout, 0);

        // ula_pronto on the last allowed wait cycle beats the timeout
        op_cmd(3'b001);
        idle();
        idle();
        repeat (TIMEOUT_CICLOS - 1) idle();
        idle(1'b1);
        chk("t4b_grava", empilha_resultado, 1);
        chk("t4b_sem_timeout", erro_timeout, 0);
        idle();

        // Reset while waiting with two queued commands
        op_cmd(3'b100);
        idle();
        idle();
        push_cmd(8'h51);
        push_cmd(8'h52);
        idle();
        chk("t6_num_cmds_antes", num_cmds, 2);
        step(1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("t6_num_cmds", num_cmds, 0);
        chk("t6_ocupado", ocupado, 0);
        chk("t6_op", ula_op_code, 0);
        chk("t6_dado", pilha_dado, 0);
        chk("t6_inicia", ula_inicia, 0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            chk("t6_sem_grava", empilha_resultado, 0);
            chk("t6_sem_push", pilha_empilha, 0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 30,
                 1'($urandom_range(0, 1)),
                 LARG_DADO'($urandom),
                 3'($urandom),
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 999) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
